// File: rtl/gsau_wb_arbiter_pkg.sv
// Shared types and widths for the GSAU writeback arbiter.
// Holds the vector register file geometry and the buffered writeback request.
package gsau_wb_arbiter_pkg;

  // Vector register file geometry.
  localparam int VEGGIEREGS = 256;
  localparam int DST_W      = $clog2(VEGGIEREGS);

  // One systolic-array psum row is one full vector register write.
  localparam int PSUM_W     = 512;

  typedef logic [DST_W-1:0]  dst_t;
  typedef logic [PSUM_W-1:0] psum_t;

  // One buffered GSAU result: destination register plus the psum row.
  typedef struct packed {
    dst_t  dst;
    psum_t data;
  } wb_req_t;

  // Source tag reported alongside each RF write so the scoreboard can clear the right entry.
  typedef enum logic {
    SRC_VL   = 1'b0,
    SRC_GSAU = 1'b1
  } wb_src_t;

endpackage

// File: rtl/gsau_wb_arbiter_if.sv
// Bus bundle for the GSAU writeback arbiter.
// The master side is the environment: the GSAU, the vector lanes and the RF stall source.
// The slave side is the arbiter itself.
interface gsau_wb_arbiter_if;
  import gsau_wb_arbiter_pkg::*;

  // GSAU result stream.
  logic  gsau_wb_valid;
  dst_t  gsau_wb_dst;
  psum_t gsau_wb_psum;
  logic  gsau_wb_ready;

  // Vector-lane writeback stream.
  logic  vl_wb_valid;
  dst_t  vl_wb_dst;
  psum_t vl_wb_data;
  logic  vl_wb_ready;

  // Vector register file write port.
  logic  rf_stall;
  logic  rf_wen;
  dst_t  rf_waddr;
  psum_t rf_wdata;
  logic  rf_wsrc;

  modport master (
    output gsau_wb_valid, gsau_wb_dst, gsau_wb_psum,
    input  gsau_wb_ready,
    output vl_wb_valid, vl_wb_dst, vl_wb_data,
    input  vl_wb_ready,
    output rf_stall,
    input  rf_wen, rf_waddr, rf_wdata, rf_wsrc
  );

  modport slave (
    input  gsau_wb_valid, gsau_wb_dst, gsau_wb_psum,
    output gsau_wb_ready,
    input  vl_wb_valid, vl_wb_dst, vl_wb_data,
    output vl_wb_ready,
    input  rf_stall,
    output rf_wen, rf_waddr, rf_wdata, rf_wsrc
  );

endinterface

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with synchronous active-low reset.
// The head entry is read combinationally; a write becomes visible at the head
// the cycle after it is pushed. Pushes while full and pops while empty are dropped.
// FIFODEPTH must be a power of two so the pointers wrap for free.
module sync_fifo #(
  parameter int FIFODEPTH = 4,
  parameter int DATAWIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push,
  input  logic                 pop,
  input  logic [DATAWIDTH-1:0] wdata,
  output logic [DATAWIDTH-1:0] rdata,
  output logic                 empty,
  output logic                 full
);

  localparam int PTR_W = $clog2(FIFODEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(FIFODEPTH);

  logic [DATAWIDTH-1:0] mem [FIFODEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [PTR_W:0]       count;
  logic                 do_push;
  logic                 do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; a simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array write.
  always_ff @(posedge clk) begin
    // NOTE: the array is deliberately not reset; emptiness is tracked by count, so stale words are never read.
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/gsau_wb_arbiter.sv
// GSAU writeback arbiter.
// Buffers GSAU psum results in a FIFO and arbitrates them against vector-lane
// writebacks for the single vector register file write port. The vector lane
// normally has priority; the buffered GSAU head wins when the lane is idle, when
// the buffer is full, or after it has lost STARVE_MAX consecutive grants.
// The RF write is registered: one cycle after a grant.
// Optional build macro: WB_PERF_CNT_EN adds saturating performance counters.
module gsau_wb_arbiter
  import gsau_wb_arbiter_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic               CLK,
  input  logic               nRST,
  gsau_wb_arbiter_if.slave   bus
`ifdef WB_PERF_CNT_EN
  ,
  output logic [31:0]        perf_gsau_wr,
  output logic [31:0]        perf_vl_stall,
  output logic [31:0]        perf_force
`endif
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  wb_req_t   push_req;
  wb_req_t   head;
  logic      fifo_empty;
  logic      fifo_full;
  logic      push;
  logic      force_g;
  logic      g_grant;
  logic      vl_grant;
  logic [SW-1:0] starve_cnt;

  logic      rf_wen_q;
  wb_src_t   rf_wsrc_q;
  dst_t      rf_waddr_q;
  psum_t     rf_wdata_q;

  // Readiness comes from registered occupancy only, so a pop never frees a slot in the same cycle.
  assign push_req          = '{dst: bus.gsau_wb_dst, data: bus.gsau_wb_psum};
  assign bus.gsau_wb_ready = !fifo_full;
  assign push              = bus.gsau_wb_valid && !fifo_full;

  sync_fifo #(
    .FIFODEPTH (DEPTH),
    .DATAWIDTH ($bits(wb_req_t))
  ) u_fifo (
    .clk   (CLK),
    .rst_n (nRST),
    .push  (push),
    .pop   (g_grant),
    .wdata (push_req),
    .rdata (head),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  // Grant decision for the RF write port; nothing is granted while the port is stalled.
  always_comb begin
    // NOTE: every output gets a default before the conditions so no latch is inferred.
    force_g  = 1'b0;
    g_grant  = 1'b0;
    vl_grant = 1'b0;
    if (!bus.rf_stall) begin
      force_g  = !fifo_empty && (fifo_full || (starve_cnt == STARVE_LIM));
      g_grant  = !fifo_empty && (force_g || !bus.vl_wb_valid);
      vl_grant = bus.vl_wb_valid && !g_grant;
    end
  end

  assign bus.vl_wb_ready = vl_grant;

  // Count consecutive grants lost by a waiting GSAU head; frozen while the port is stalled.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      starve_cnt <= '0;
    end else if (fifo_empty) begin
      starve_cnt <= '0;
    end else if (!bus.rf_stall) begin
      if (g_grant) begin
        starve_cnt <= '0;
      end else if (vl_grant && (starve_cnt != STARVE_LIM)) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

  // Registered RF write: load the winner on a grant, otherwise drop enable and hold the rest.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      rf_wen_q   <= 1'b0;
      rf_wsrc_q  <= SRC_VL;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else if (g_grant) begin
      rf_wen_q   <= 1'b1;
      rf_wsrc_q  <= SRC_GSAU;
      rf_waddr_q <= head.dst;
      rf_wdata_q <= head.data;
    end else if (vl_grant) begin
      rf_wen_q   <= 1'b1;
      rf_wsrc_q  <= SRC_VL;
      rf_waddr_q <= bus.vl_wb_dst;
      rf_wdata_q <= bus.vl_wb_data;
    end else begin
      rf_wen_q   <= 1'b0;
    end
  end

  assign bus.rf_wen   = rf_wen_q;
  assign bus.rf_wsrc  = rf_wsrc_q;
  assign bus.rf_waddr = rf_waddr_q;
  assign bus.rf_wdata = rf_wdata_q;

`ifdef WB_PERF_CNT_EN
  logic vl_stalled;
  assign vl_stalled = bus.vl_wb_valid && !vl_grant;

  // Saturating event counters for GSAU writes, vector-lane stall cycles and forced grants.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      perf_gsau_wr  <= '0;
      perf_vl_stall <= '0;
      perf_force    <= '0;
    end else begin
      if (g_grant && (perf_gsau_wr != '1))           perf_gsau_wr  <= perf_gsau_wr + 32'd1;
      if (vl_stalled && (perf_vl_stall != '1))       perf_vl_stall <= perf_vl_stall + 32'd1;
      if (g_grant && force_g && (perf_force != '1))  perf_force    <= perf_force + 32'd1;
    end
  end
`endif

  // Pushing into a full buffer is an upstream protocol violation; the push is dropped.
  a_no_push_when_full: assert property (@(posedge CLK) disable iff (!nRST)
    !(bus.gsau_wb_valid && !bus.gsau_wb_ready));

endmodule

// File: tb/tb_gsau_wb_arbiter.sv
// Self-checking bench for gsau_wb_arbiter.
// A queue-based reference model applies the arbitration rules each cycle;
// directed scenarios add fixed expectations for latency, starvation, full and reset.
module tb_gsau_wb_arbiter;
  import gsau_wb_arbiter_pkg::*;

  localparam int DEPTH      = 4;
  localparam int STARVE_MAX = 8;

  logic CLK  = 1'b0;
  logic nRST = 1'b0;

  gsau_wb_arbiter_if bus ();

`ifdef WB_PERF_CNT_EN
  logic [31:0] perf_gsau_wr;
  logic [31:0] perf_vl_stall;
  logic [31:0] perf_force;
`endif

  gsau_wb_arbiter #(
    .DEPTH      (DEPTH),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
`ifdef WB_PERF_CNT_EN
    ,
    .perf_gsau_wr  (perf_gsau_wr),
    .perf_vl_stall (perf_vl_stall),
    .perf_force    (perf_force)
`endif
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  // Reference model state.
  wb_req_t mq[$];
  int      m_starve = 0;
  logic    exp_wen = 1'b0;
  logic    exp_src = 1'b0;
  dst_t    exp_addr = '0;
  psum_t   exp_data = '0;
  logic    exp_gready, exp_vready;
  logic    obs_gready, obs_vready;
  dst_t    g_order[$];

  function automatic psum_t rand_psum();
    psum_t p;
    for (int k = 0; k < PSUM_W / 32; k++) p[k*32 +: 32] = $urandom();
    return p;
  endfunction

  // Drive one cycle of inputs from the negedge, predict, and return at the following negedge.
  task automatic cycle(input logic rst, input logic gv, input dst_t gd, input psum_t gp,
                       input logic vv, input dst_t vd, input psum_t vdat, input logic st);
    bit nonempty, forced, gwin, vwin;
    wb_req_t h;
    nRST              = !rst;
    bus.gsau_wb_valid = gv;
    bus.gsau_wb_dst   = gd;
    bus.gsau_wb_psum  = gp;
    bus.vl_wb_valid   = vv;
    bus.vl_wb_dst     = vd;
    bus.vl_wb_data    = vdat;
    bus.rf_stall      = st;
    #1;
    nonempty   = (mq.size() != 0);
    forced     = nonempty && (mq.size() == DEPTH || m_starve == STARVE_MAX);
    gwin       = !st && nonempty && (forced || !vv);
    vwin       = !st && vv && !gwin;
    exp_gready = (mq.size() != DEPTH);
    exp_vready = vwin;
    obs_gready = bus.gsau_wb_ready;
    obs_vready = bus.vl_wb_ready;
    @(posedge CLK);
    if (rst) begin
      mq.delete();
      m_starve = 0;
      exp_wen  = 1'b0;
      exp_src  = 1'b0;
      exp_addr = '0;
      exp_data = '0;
    end else begin
      if (!nonempty) m_starve = 0;
      else if (!st) begin
        if (gwin) m_starve = 0;
        else if (vwin && m_starve < STARVE_MAX) m_starve = m_starve + 1;
      end
      if (gwin) begin
        h        = mq.pop_front();
        exp_wen  = 1'b1;
        exp_src  = 1'b1;
        exp_addr = h.dst;
        exp_data = h.data;
      end else if (vwin) begin
        exp_wen  = 1'b1;
        exp_src  = 1'b0;
        exp_addr = vd;
        exp_data = vdat;
      end else begin
        exp_wen  = 1'b0;
      end
      if (gv && exp_gready) mq.push_back('{dst: gd, data: gp});
    end
    @(negedge CLK);
    if (bus.rf_wen && bus.rf_wsrc) g_order.push_back(bus.rf_waddr);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) cycle(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
    checks++;
    if (bus.rf_wen !== 1'b0 || bus.rf_wsrc !== 1'b0 || bus.rf_waddr !== '0 || bus.rf_wdata !== '0) begin
      errors++;
      $display("FAIL reset rf: wen=%b src=%b addr=%h want 0 0 00, data zero=%0d",
               bus.rf_wen, bus.rf_wsrc, bus.rf_waddr, bus.rf_wdata == '0);
    end
    checks++;
    if (bus.gsau_wb_ready !== 1'b1 || bus.vl_wb_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset ready: gsau=%b vl=%b want gsau=1 vl=0", bus.gsau_wb_ready, bus.vl_wb_ready);
    end
  endtask

  task automatic test_single_push();
    psum_t a5;
    a5 = {64{8'hA5}};
    cycle(1'b0, 1'b1, 8'h05, a5, 1'b0, '0, '0, 1'b0);
    checks++;
    if (bus.rf_wen !== 1'b0 || obs_gready !== 1'b1) begin
      errors++;
      $display("FAIL single push cycle: rf_wen=%b gsau_ready=%b want 0 1", bus.rf_wen, obs_gready);
    end
    cycle(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
    checks++;
    if (bus.rf_wen !== 1'b1 || bus.rf_waddr !== 8'h05 || bus.rf_wsrc !== 1'b1 || bus.rf_wdata !== a5) begin
      errors++;
      $display("FAIL single write: wen=%b addr=%h src=%b data_ok=%0d want 1 05 1 1",
               bus.rf_wen, bus.rf_waddr, bus.rf_wsrc, bus.rf_wdata == a5);
    end
    checks++;
    if (obs_gready !== 1'b1) begin
      errors++;
      $display("FAIL single gsau_ready: got %b want 1", obs_gready);
    end
    cycle(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
    checks++;
    if (bus.rf_wen !== 1'b0 || bus.rf_waddr !== 8'h05) begin
      errors++;
      $display("FAIL single idle: wen=%b addr=%h want 0 05", bus.rf_wen, bus.rf_waddr);
    end
  endtask

  task automatic test_starvation();
    int first_force, second_force;
    psum_t vdat;
    first_force  = -1;
    second_force = -1;
    vdat = rand_psum();
    cycle(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
    for (int i = 0; i <= 24; i++) begin
      cycle(1'b0, (i == 0 || i == 13), 8'h40 + 8'(i), rand_psum(), 1'b1, 8'h03, vdat, 1'b0);
      checks++;
      if (obs_vready !== exp_vready || obs_gready !== exp_gready) begin
        errors++;
        $display("FAIL starve ready c%0d: vl=%b gsau=%b want vl=%b gsau=%b",
                 i, obs_vready, obs_gready, exp_vready, exp_gready);
      end
      checks++;
      if ({bus.rf_wen, bus.rf_wsrc, bus.rf_waddr} !== {exp_wen, exp_src, exp_addr} || bus.rf_wdata !== exp_data) begin
        errors++;
        $display("FAIL starve rf c%0d: wen=%b src=%b addr=%h want %b %b %h",
                 i, bus.rf_wen, bus.rf_wsrc, bus.rf_waddr, exp_wen, exp_src, exp_addr);
      end
      if (!obs_vready && i < 13 && first_force < 0) first_force = i;
      if (!obs_vready && i >= 13 && second_force < 0) second_force = i;
`ifdef WB_PERF_CNT_EN
      if (i == 12) begin
        checks++;
        if (perf_force !== 32'd1 || perf_gsau_wr !== 32'd1 || perf_vl_stall !== 32'd1) begin
          errors++;
          $display("FAIL perf counters: force=%0d gsau_wr=%0d vl_stall=%0d want 1 1 1",
                   perf_force, perf_gsau_wr, perf_vl_stall);
        end
      end
`endif
    end
    checks++;
    if (first_force !== 9) begin
      errors++;
      $display("FAIL starve first force: cycle %0d want 9", first_force);
    end
    checks++;
    if (second_force !== 22) begin
      errors++;
      $display("FAIL starve counter restart: forced at cycle %0d want 22", second_force);
    end
  endtask

  task automatic test_full_stall();
    dst_t want[$];
    g_order.delete();
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b1, 8'h10 + 8'(i), rand_psum(), 1'b1, 8'h03, '0, 1'b1);
      want.push_back(8'h10 + 8'(i));
      checks++;
      if (obs_vready !== 1'b0 || bus.rf_wen !== 1'b0) begin
        errors++;
        $display("FAIL stall push %0d: vl_ready=%b rf_wen=%b want 0 0", i, obs_vready, bus.rf_wen);
      end
    end
    cycle(1'b0, 1'b0, '0, '0, 1'b1, 8'h03, '0, 1'b1);
    checks++;
    if (obs_gready !== 1'b0) begin
      errors++;
      $display("FAIL full gsau_ready: got %b want 0", obs_gready);
    end
    for (int i = 0; i < 26; i++) begin
      cycle(1'b0, 1'b0, '0, '0, (i < 20), 8'h03, 512'h1234, 1'b0);
      if (i == 0) begin
        checks++;
        if (obs_vready !== 1'b0 || bus.rf_wsrc !== 1'b1 || bus.rf_waddr !== 8'h10) begin
          errors++;
          $display("FAIL full force: vl_ready=%b src=%b addr=%h want 0 1 10", obs_vready, bus.rf_wsrc, bus.rf_waddr);
        end
      end
      checks++;
      if ({bus.rf_wen, bus.rf_wsrc, bus.rf_waddr} !== {exp_wen, exp_src, exp_addr} || obs_vready !== exp_vready) begin
        errors++;
        $display("FAIL drain c%0d: wen=%b src=%b addr=%h vl=%b want %b %b %h %b",
                 i, bus.rf_wen, bus.rf_wsrc, bus.rf_waddr, obs_vready, exp_wen, exp_src, exp_addr, exp_vready);
      end
    end
    checks++;
    if (g_order != want) begin
      errors++;
      $display("FAIL full drain order: got %p want %p", g_order, want);
    end
  endtask

  task automatic test_wrap_simul();
    dst_t want[$];
    g_order.delete();
    for (int i = 0; i < 14; i++) begin
      cycle(1'b0, (i < 10), 8'hC0 + 8'(i), rand_psum(), 1'b0, '0, '0, (i < 2));
      if (i < 10) want.push_back(8'hC0 + 8'(i));
      if (i >= 2 && i < 10) begin
        checks++;
        if (obs_gready !== 1'b1 || bus.rf_wen !== 1'b1 || bus.rf_waddr !== 8'hC0 + 8'(i - 2)) begin
          errors++;
          $display("FAIL push+pop c%0d: ready=%b wen=%b addr=%h want 1 1 %h",
                   i, obs_gready, bus.rf_wen, bus.rf_waddr, 8'hC0 + 8'(i - 2));
        end
      end
      checks++;
      if ({bus.rf_wen, bus.rf_wsrc, bus.rf_waddr} !== {exp_wen, exp_src, exp_addr} || bus.rf_wdata !== exp_data) begin
        errors++;
        $display("FAIL wrap rf c%0d: wen=%b src=%b addr=%h want %b %b %h",
                 i, bus.rf_wen, bus.rf_wsrc, bus.rf_waddr, exp_wen, exp_src, exp_addr);
      end
    end
    checks++;
    if (g_order != want) begin
      errors++;
      $display("FAIL wrap order: got %p want %p", g_order, want);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 8'h70 + 8'(i), rand_psum(), 1'b0, '0, '0, 1'b1);
    cycle(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
    checks++;
    if (bus.rf_wen !== 1'b0 || bus.gsau_wb_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid reset: rf_wen=%b gsau_ready=%b want 0 1", bus.rf_wen, bus.gsau_wb_ready);
    end
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
      checks++;
      if (bus.rf_wen !== 1'b0) begin
        errors++;
        $display("FAIL stale write after reset c%0d: rf_wen=%b addr=%h want wen 0", i, bus.rf_wen, bus.rf_waddr);
      end
    end
  endtask

  task automatic test_random();
    logic rst, gv, vv, st;
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 96) == 0);
      gv  = ($urandom_range(0, 1) == 1) && (mq.size() != DEPTH);
      vv  = ($urandom_range(0, 2) != 0);
      st  = ($urandom_range(0, 3) == 0);
      cycle(rst, gv, dst_t'($urandom()), rand_psum(), vv, dst_t'($urandom()), rand_psum(), st);
      checks++;
      if (obs_vready !== exp_vready || obs_gready !== exp_gready) begin
        errors++;
        $display("FAIL random ready c%0d: vl=%b gsau=%b want vl=%b gsau=%b",
                 i, obs_vready, obs_gready, exp_vready, exp_gready);
      end
      checks++;
      if ({bus.rf_wen, bus.rf_wsrc, bus.rf_waddr} !== {exp_wen, exp_src, exp_addr} || bus.rf_wdata !== exp_data) begin
        errors++;
        $display("FAIL random rf c%0d: wen=%b src=%b addr=%h want %b %b %h data_ok=%0d",
                 i, bus.rf_wen, bus.rf_wsrc, bus.rf_waddr, exp_wen, exp_src, exp_addr, bus.rf_wdata == exp_data);
      end
    end
  endtask

  initial begin
    bus.gsau_wb_valid = 1'b0;
    bus.gsau_wb_dst   = '0;
    bus.gsau_wb_psum  = '0;
    bus.vl_wb_valid   = 1'b0;
    bus.vl_wb_dst     = '0;
    bus.vl_wb_data    = '0;
    bus.rf_stall      = 1'b0;
    @(negedge CLK);
    test_reset();
    test_single_push();
    test_starvation();
    test_full_stall();
    test_wrap_simul();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
